// File: rtl/led_sequencer.sv
// LED sequencer: drives NUM_LEDS outputs from a run-time programmable
// prescaler. Display modes are toggle-sequence, chase, bounce and
// all-blink. The prescaler can be paused, and while it is paused a
// single-step input advances the sequence.
//
// state (mode_q) | meaning
// TOGGLE_SEQ     | invert leds[pos] on each advance, pos wraps upward
// CHASE          | single lit LED moving upward with wrap
// BOUNCE         | single lit LED moving up then down, end LEDs lit once
// ALL_BLINK      | every LED inverts on each advance, pos stays 0
module led_sequencer #(
  parameter int NUM_LEDS  = 4,
  parameter int CNT_WIDTH = 32,
  parameter int POS_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 step,
  input  logic [1:0]           mode,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic [NUM_LEDS-1:0]  leds,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 tick
);

  typedef enum logic [1:0] {
    TOGGLE_SEQ = 2'b00,
    CHASE      = 2'b01,
    BOUNCE     = 2'b10,
    ALL_BLINK  = 2'b11
  } mode_t;

  localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(NUM_LEDS - 1);

  mode_t                mode_q;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] lim_eff;
  logic                 at_limit;
  logic                 adv;
  logic                 dir_down;
  logic [POS_WIDTH-1:0] pos_wrap;
  logic [POS_WIDTH-1:0] pos_bounce;
  logic                 dir_bounce;

  // Shifting a NUM_LEDS-wide one keeps the result inside the vector even
  // when pos is wider than needed for non-power-of-2 NUM_LEDS.
  function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_WIDTH-1:0] p);
    onehot = NUM_LEDS'(1) << p;
  endfunction

  // Prescaler terminal compare; >= lets a lowered limit fire immediately.
  always_comb begin
    lim_eff  = (limit == '0) ? CNT_WIDTH'(1) : limit;
    at_limit = (count >= lim_eff - CNT_WIDTH'(1));
    adv      = en ? at_limit : step;
  end

  // Next position for the wrapping modes and for the bouncing mode.
  always_comb begin
    pos_wrap   = (pos == POS_LAST) ? '0 : pos + POS_WIDTH'(1);
    pos_bounce = pos;
    dir_bounce = dir_down;
    if (NUM_LEDS == 1) begin
      pos_bounce = '0;
    end else if (!dir_down) begin
      if (pos == POS_LAST) begin
        dir_bounce = 1'b1;
        pos_bounce = pos - POS_WIDTH'(1);
      end else begin
        pos_bounce = pos + POS_WIDTH'(1);
      end
    end else begin
      if (pos == '0) begin
        dir_bounce = 1'b0;
        pos_bounce = pos + POS_WIDTH'(1);
      end else begin
        pos_bounce = pos - POS_WIDTH'(1);
      end
    end
  end

  // Sequencer state: reset, mode-change restart, then prescaled advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds     <= '0;
      pos      <= '0;
      tick     <= 1'b0;
      count    <= '0;
      dir_down <= 1'b0;
      mode_q   <= mode_t'(mode);
    end else if (mode_t'(mode) != mode_q) begin
      leds     <= '0;
      pos      <= '0;
      tick     <= 1'b0;
      count    <= '0;
      dir_down <= 1'b0;
      mode_q   <= mode_t'(mode);
    end else begin
      tick <= adv;
      if (en) begin
        count <= at_limit ? '0 : count + CNT_WIDTH'(1);
      end
      if (adv) begin
        case (mode_q)
          TOGGLE_SEQ: begin
            leds <= leds ^ onehot(pos);
            pos  <= pos_wrap;
          end
          CHASE: begin
            leds <= onehot(pos_wrap);
            pos  <= pos_wrap;
          end
          BOUNCE: begin
            leds     <= onehot(pos_bounce);
            pos      <= pos_bounce;
            dir_down <= dir_bounce;
          end
          ALL_BLINK: begin
            leds <= ~leds;
          end
          default: begin
            leds <= leds;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: three instances (4, 5 and 1 LEDs) share one
// set of inputs and are compared every cycle against a behavioural model.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, step;
  logic [1:0]  mode;
  logic [31:0] limit;

  logic [3:0]  leds4;
  logic [1:0]  pos4;
  logic        tick4;
  logic [4:0]  leds5;
  logic [2:0]  pos5;
  logic        tick5;
  logic [0:0]  leds1;
  logic [0:0]  pos1;
  logic        tick1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_sequencer #(.NUM_LEDS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .step(step), .mode(mode), .limit(limit),
    .leds(leds4), .pos(pos4), .tick(tick4));
  led_sequencer #(.NUM_LEDS(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .step(step), .mode(mode), .limit(limit),
    .leds(leds5), .pos(pos5), .tick(tick5));
  led_sequencer #(.NUM_LEDS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .step(step), .mode(mode), .limit(limit),
    .leds(leds1), .pos(pos1), .tick(tick1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: positions as plain integers, bounce as a triangle wave.
  int          NS[3] = '{4, 5, 1};
  longint      m_cnt[3];
  int          m_pos[3];
  int          m_phase[3];
  int          m_mode[3];
  logic [31:0] m_leds[3];
  logic        m_tick[3];

  always @(posedge clk) begin
    longint lim;
    logic   a;
    int     n;
    logic [31:0] mask;
    lim = (limit == 0) ? 1 : longint'(limit);
    for (int i = 0; i < 3; i++) begin
      n    = NS[i];
      mask = (32'd1 << n) - 32'd1;
      if (rst || int'(mode) != m_mode[i]) begin
        m_leds[i] = 0; m_pos[i] = 0; m_tick[i] = 0;
        m_cnt[i] = 0; m_phase[i] = 0; m_mode[i] = int'(mode);
      end else begin
        a = en ? (m_cnt[i] + 1 >= lim) : step;
        if (en) m_cnt[i] = a ? 0 : m_cnt[i] + 1;
        m_tick[i] = a;
        if (a) begin
          case (m_mode[i])
            0: begin
              m_leds[i] = m_leds[i] ^ (32'd1 << m_pos[i]);
              m_pos[i]  = (m_pos[i] + 1) % n;
            end
            1: begin
              m_pos[i]  = (m_pos[i] + 1) % n;
              m_leds[i] = 32'd1 << m_pos[i];
            end
            2: begin
              if (n > 1) begin
                m_phase[i] = (m_phase[i] + 1) % (2 * n - 2);
                m_pos[i]   = (m_phase[i] < n) ? m_phase[i] : 2 * n - 2 - m_phase[i];
              end
              m_leds[i] = 32'd1 << m_pos[i];
            end
            default: m_leds[i] = ~m_leds[i] & mask;
          endcase
        end
      end
    end
  end

  task automatic compare_all();
    check("leds_n4", {28'd0, leds4}, m_leds[0]);
    check("pos_n4",  {30'd0, pos4},  m_pos[0]);
    check("tick_n4", {31'd0, tick4}, {31'd0, m_tick[0]});
    check("leds_n5", {27'd0, leds5}, m_leds[1]);
    check("pos_n5",  {29'd0, pos5},  m_pos[1]);
    check("tick_n5", {31'd0, tick5}, {31'd0, m_tick[1]});
    check("leds_n1", {31'd0, leds1}, m_leds[2]);
    check("pos_n1",  {31'd0, pos1},  m_pos[2]);
    check("tick_n1", {31'd0, tick1}, {31'd0, m_tick[2]});
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [3:0] toggle_exp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    int cyc;
    rst = 1'b1; en = 1'b1; step = 1'b0; mode = 2'b00; limit = 32'd3;
    @(negedge clk);
    cycle();
    check("reset_leds", {28'd0, leds4}, 32'd0);
    check("reset_tick", {31'd0, tick4}, 32'd0);
    rst = 1'b0;

    // Toggle sequence with explicit expected patterns and 3-cycle period.
    for (int i = 0; i < 8; i++) begin
      cyc = 0;
      do begin cycle(); cyc++; end while (!tick4 && cyc < 6);
      check("toggle_period", cyc, 3);
      check("toggle_leds", {28'd0, leds4}, {28'd0, toggle_exp[i]});
    end
    run(1);

    // Chase entered mid-run: clean restart on the switching edge.
    mode = 2'b01;
    cycle();
    check("chase_restart_leds", {28'd0, leds4}, 32'd0);
    check("chase_restart_tick", {31'd0, tick4}, 32'd0);
    run(14);

    // Bounce at limit 1 advances every cycle.
    mode = 2'b10; limit = 32'd1;
    run(12);

    // All-blink with limit 0: every cycle, tick held high.
    mode = 2'b11; limit = 32'd0;
    cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("blink_tick", {31'd0, tick4}, 32'd1);
      check("blink_leds", {28'd0, leds4}, (i % 2 == 0) ? 32'hF : 32'h0);
    end

    // Pause with count=1, step while paused, step ignored while running.
    mode = 2'b01; limit = 32'd5;
    cycle();
    run(1);
    en = 1'b0;
    run(10);
    step = 1'b1;
    cycle();
    check("step_tick", {31'd0, tick4}, 32'd1);
    step = 1'b0;
    run(2);
    en = 1'b1; step = 1'b1;
    cyc = 0;
    do begin cycle(); cyc++; end while (!tick4 && cyc < 8);
    check("resume_latency", cyc, 4);
    step = 1'b0;
    run(6);

    // Limit lowered below the running count.
    mode = 2'b00; limit = 32'd25;
    cycle();
    run(20);
    limit = 32'd10;
    cycle();
    check("lowered_limit_tick", {31'd0, tick4}, 32'd1);
    run(25);

    // Reset beats step and a pending mode change.
    mode = 2'b10; limit = 32'd2;
    cycle();
    run(7);
    rst = 1'b1; step = 1'b1; en = 1'b0; mode = 2'b11;
    cycle();
    check("midrst_leds", {27'd0, leds5}, 32'd0);
    check("midrst_pos", {29'd0, pos5}, 32'd0);
    check("midrst_tick", {31'd0, tick5}, 32'd0);
    rst = 1'b0; step = 1'b0; en = 1'b1;

    // Bounce and chase for step-driven coverage on all widths.
    mode = 2'b10; en = 1'b0; step = 1'b1;
    cycle();
    run(20);
    mode = 2'b01;
    cycle();
    run(12);
    step = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 3) != 0);
      step = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) limit = $urandom_range(0, 9);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
